fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the 5-stage pipeline.
- Owns the architectural PC register and drives it to the PC adder and to instruction memory.
- Takes the adder's PC+4 result as the sequential next PC, and applies branch/jump redirects from EX.
- Issues single-outstanding imem requests and delivers fetched instructions into the IF/ID pipeline register under a valid/ready handshake with decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/data width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
pc_o  out  XLEN  current PC; feeds PC adder input and imem address.
pc_plus4_i  in  XLEN  PC adder output (pc_o + 4, modulo 2^32).
redirect_valid_i  in  1  branch taken / jump from EX this cycle.
redirect_target_i  in  XLEN  redirect target address.
imem_req_valid_o  out  1  fetch request valid; address is pc_o.
imem_req_ready_i  in  1  imem accepts the request.
imem_rsp_valid_i  in  1  instruction word returned; always accepted (no back-pressure).
imem_rsp_data_i  in  32  instruction word.
ifid_valid_o  out  1  IF/ID holds a valid instruction.
ifid_ready_i  in  1  decode consumes IF/ID this cycle (low = hazard stall).
ifid_pc_o  out  XLEN  PC of the instruction in IF/ID.
ifid_pc_plus4_o  out  XLEN  PC+4 of the instruction in IF/ID (for JAL/JALR link).
ifid_instr_o  out  32  instruction word in IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous): pc_o = RESET_PC; state = REQ; kill = 0; hold buffer empty; ifid_valid_o = 0; ifid_pc_o / ifid_pc_plus4_o / ifid_instr_o = 0; imem_req_valid_o = 0 while in reset.
- A reset asserted mid-transaction abandons the outstanding request. The first request is issued in the first cycle after rst_n rises.
- FSM states:
  - REQ: imem_req_valid_o = 1. On imem_req_ready_i: latch req_pc = pc_o and req_pc4 = pc_plus4_i; pc_o <= pc_plus4_i; go to WAIT.
  - WAIT: imem_req_valid_o = 0. On imem_rsp_valid_i:
    - kill = 1: discard the word, clear kill, go to REQ.
    - kill = 0 and IF/ID free: load IF/ID with {req_pc, req_pc4, data}, ifid_valid_o <= 1, go to REQ.
    - kill = 0 and IF/ID not free: store the word in the hold buffer, go to HOLD.
  - HOLD: imem_req_valid_o = 0. When IF/ID becomes free, move the hold buffer into IF/ID and go to REQ.
- "IF/ID free" = !ifid_valid_o || ifid_ready_i. If ifid_ready_i is high and no new word is loaded, ifid_valid_o <= 0.
- Minimum fetch latency is 1 cycle from request acceptance to response. Throughput is at most one instruction per 2 cycles (single outstanding request).
- Redirect (redirect_valid_i = 1) has highest priority after reset:
  - pc_o <= {redirect_target_i[31:2], 2'b00}; the low two bits are forced to zero.
  - ifid_valid_o <= 0 (flush), regardless of ifid_ready_i.
  - In WAIT: set kill, unless imem_rsp_valid_i is high in the same cycle; in that case the word is discarded directly and the state goes to REQ.
  - In HOLD: the hold buffer is discarded and the state goes to REQ.
  - In REQ with imem_req_ready_i high in the same cycle: the request is still issued (old PC) and kill is set; pc_o takes the redirect target, not pc_plus4_i.
- Wrap-around: pc_plus4_i from 32'hFFFF_FFFC is 32'h0000_0000, and it is taken as-is.
- imem_rsp_valid_i outside WAIT is ignored.
- All outputs are registered, except imem_req_valid_o, which is decoded from state.

Test Plan:
- Reset/sequential: RESET_PC = 0, imem ready always, 1-cycle response returning 32'h00000013 → IF/ID presents PC 0x0, 0x4, 0x8 on every second cycle; ifid_pc_plus4_o = 0x4, 0x8, 0xC.
- Decode stall: ifid_ready_i low for 5 cycles with IF/ID full and a response arriving → state goes to HOLD and no new request is issued. On ready rising, the held word enters IF/ID next cycle with the correct PC, with no loss or duplication.
- Redirect in WAIT: request for 0x10 outstanding, redirect to 0x200 → the 0x10 response is dropped, the next request is at 0x200, and ifid_valid_o is 0 until the 0x200 word arrives.
- Simultaneous events: redirect to 0x1003 in the same cycle as imem_req_ready_i in REQ → pc_o = 0x1000, the old word is killed, and only the instruction at 0x1000 reaches IF/ID.
- Wrap and async reset: pc_o = 0xFFFFFFFC fetches, then pc_o becomes 0x0. Asserting rst_n low mid-WAIT makes outputs reset immediately (no clock edge needed) and the late response is ignored.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch front end of the 5-stage pipeline. Owns the architectural
// PC, issues one outstanding instruction-memory request at a time, and hands
// fetched words to decode through the IF/ID register under valid/ready.
// Branch/jump redirects from EX replace the PC, flush IF/ID and kill any
// request still in flight.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   pc_o                current PC (to PC adder and imem address)
//   pc_plus4_i          PC adder result, pc_o + 4 modulo 2^XLEN
//   redirect_valid_i    taken branch / jump from EX this cycle
//   redirect_target_i   redirect address (low two bits are ignored)
//   imem_req_valid_o    fetch request for address pc_o
//   imem_req_ready_i    imem accepts the request
//   imem_rsp_valid_i    instruction word returned (always accepted)
//   imem_rsp_data_i     instruction word
//   ifid_valid_o        IF/ID holds a valid instruction
//   ifid_ready_i        decode consumes IF/ID this cycle
//   ifid_pc_o           PC of the IF/ID instruction
//   ifid_pc_plus4_o     PC+4 of the IF/ID instruction (link value)
//   ifid_instr_o        IF/ID instruction word
//
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            ifid_valid_o,
    input  logic            ifid_ready_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic [31:0]     ifid_instr_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] reqPc_q, reqPc_d;
    logic [XLEN-1:0] reqPc4_q, reqPc4_d;
    logic            kill_q, kill_d;
    logic [31:0]     holdInstr_q, holdInstr_d;
    logic            ifidValid_q, ifidValid_d;
    logic [XLEN-1:0] ifidPc_q, ifidPc_d;
    logic [XLEN-1:0] ifidPc4_q, ifidPc4_d;
    logic [31:0]     ifidInstr_q, ifidInstr_d;

    logic            ifidFree;
    logic [XLEN-1:0] redirectPc;

    // IF/ID can take a new word when it is empty or decode drains it this cycle.
    assign ifidFree = !ifidValid_q || ifid_ready_i;

    // Redirect targets are forced word-aligned by masking the low two bits.
    assign redirectPc = redirect_target_i & ~{{(XLEN-2){1'b0}}, 2'b11};

    // Gating with rst_n keeps the request low for the whole time reset is held,
    // even though the state register already sits in S_REQ.
    assign imem_req_valid_o = rst_n && (state_q == S_REQ);

    assign pc_o            = pc_q;
    assign ifid_valid_o    = ifidValid_q;
    assign ifid_pc_o       = ifidPc_q;
    assign ifid_pc_plus4_o = ifidPc4_q;
    assign ifid_instr_o    = ifidInstr_q;

    // Next-state logic. A redirect overrides normal sequencing: it replaces the
    // PC, flushes IF/ID and makes sure whatever is in flight never reaches
    // decode (killed later if still outstanding, dropped now if it arrives in
    // the same cycle, or discarded from the hold buffer).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        reqPc_d     = reqPc_q;
        reqPc4_d    = reqPc4_q;
        kill_d      = kill_q;
        holdInstr_d = holdInstr_q;
        ifidValid_d = ifidValid_q;
        ifidPc_d    = ifidPc_q;
        ifidPc4_d   = ifidPc4_q;
        ifidInstr_d = ifidInstr_q;

        // Decode consumed the entry; a load below re-validates it.
        if (ifid_ready_i) begin
            ifidValid_d = 1'b0;
        end

        if (redirect_valid_i) begin
            pc_d        = redirectPc;
            ifidValid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // The old-PC request still goes out, but is marked dead.
                    if (imem_req_ready_i) begin
                        reqPc_d  = pc_q;
                        reqPc4_d = pc_plus4_i;
                        kill_d   = 1'b1;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready_i) begin
                        reqPc_d  = pc_q;
                        reqPc4_d = pc_plus4_i;
                        pc_d     = pc_plus4_i;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (ifidFree) begin
                            ifidValid_d = 1'b1;
                            ifidPc_d    = reqPc_q;
                            ifidPc4_d   = reqPc4_q;
                            ifidInstr_d = imem_rsp_data_i;
                            state_d     = S_REQ;
                        end else begin
                            holdInstr_d = imem_rsp_data_i;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The request PC registers still describe the held word.
                    if (ifidFree) begin
                        ifidValid_d = 1'b1;
                        ifidPc_d    = reqPc_q;
                        ifidPc4_d   = reqPc4_q;
                        ifidInstr_d = holdInstr_q;
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            reqPc_q     <= '0;
            reqPc4_q    <= '0;
            kill_q      <= 1'b0;
            holdInstr_q <= '0;
            ifidValid_q <= 1'b0;
            ifidPc_q    <= '0;
            ifidPc4_q   <= '0;
            ifidInstr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            reqPc_q     <= reqPc_d;
            reqPc4_q    <= reqPc4_d;
            kill_q      <= kill_d;
            holdInstr_q <= holdInstr_d;
            ifidValid_q <= ifidValid_d;
            ifidPc_q    <= ifidPc_d;
            ifidPc4_q   <= ifidPc4_d;
            ifidInstr_q <= ifidInstr_d;
        end
    end

endmodule
